// File: rtl/multi_spawn_timer.sv
// multi_spawn_timer
//   Multi-channel respawn timer. Each channel is started by an "eaten" pulse,
//   counts a per-channel delay in prescaled ticks, and then emits a one-cycle
//   spawn pulse. All channels share a single free-running prescaler.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   pause        level; freezes the prescaler, so no channel counts
//   eaten        per-channel start/retrigger pulse
//   clear        per-channel abort (highest priority)
//   auto_reload  per-channel repeat mode
//   delay        per-channel delay in ticks, channel i at [i*CNT_W +: CNT_W]
//   spawn        registered one-cycle expiry pulse per channel
//   busy         1 while a channel is counting
//   remaining    per-channel ticks left, same packing as delay
module multi_spawn_timer #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 4,
  parameter int PRESCALER = 24999999
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pause,
  input  logic [NUM_CH-1:0]       eaten,
  input  logic [NUM_CH-1:0]       clear,
  input  logic [NUM_CH-1:0]       auto_reload,
  input  logic [NUM_CH*CNT_W-1:0] delay,
  output logic [NUM_CH-1:0]       spawn,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH*CNT_W-1:0] remaining
);

  // A PRESCALER of 0 would give a zero-width counter; keep at least one bit.
  localparam int PW = (PRESCALER > 0) ? $clog2(PRESCALER + 1) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(PRESCALER);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

  // ---------------------------------------------------------------------------
  // Shared prescaler. Loads never restart it, so the first decrement after a
  // load lands anywhere from 1 to PRESCALER+1 cycles later.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_reg;
  logic [PW-1:0] presc_next;
  logic          tick;

  assign tick = (presc_reg == PRESC_TC) && !pause;

  always_comb begin
    presc_next = presc_reg;
    if (!pause) begin
      if (presc_reg == PRESC_TC) begin
        presc_next = '0;
      end else begin
        presc_next = presc_reg + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel counters. Priority: clear > eaten > tick.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      ch_state_t        state_reg;
      ch_state_t        state_next;
      logic [CNT_W-1:0] rem_reg;
      logic [CNT_W-1:0] rem_next;
      logic             spawn_reg;
      logic             spawn_next;
      logic [CNT_W-1:0] dly;

      assign dly = delay[gi*CNT_W +: CNT_W];

      always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        spawn_next = 1'b0;
        if (clear[gi]) begin
          // Abort wins even over a coinciding final tick: no spawn.
          state_next = IDLE;
          rem_next   = '0;
        end else if (eaten[gi]) begin
          if (dly != '0) begin
            // Retrigger: reload and ignore any tick in this cycle.
            state_next = RUN;
            rem_next   = dly;
          end else begin
            // Zero delay means "spawn immediately".
            spawn_next = 1'b1;
            state_next = IDLE;
            rem_next   = '0;
          end
        end else if (tick && (state_reg == RUN)) begin
          if (rem_reg > CNT_W'(1)) begin
            rem_next = rem_reg - CNT_W'(1);
          end else begin
            // Expiry. A zero count in RUN cannot occur, but treating it as
            // expiry keeps the counter from ever wrapping.
            spawn_next = 1'b1;
            if (auto_reload[gi] && (dly != '0)) begin
              state_next = RUN;
              rem_next   = dly;
            end else begin
              state_next = IDLE;
              rem_next   = '0;
            end
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_reg <= IDLE;
          rem_reg   <= '0;
          spawn_reg <= 1'b0;
        end else begin
          state_reg <= state_next;
          rem_reg   <= rem_next;
          spawn_reg <= spawn_next;
        end
      end

      assign spawn[gi]                     = spawn_reg;
      assign busy[gi]                      = (state_reg == RUN);
      assign remaining[gi*CNT_W +: CNT_W]  = rem_reg;
    end
  endgenerate

endmodule

// File: tb/tb_multi_spawn_timer.sv
// Directed testbench for multi_spawn_timer with PRESCALER=3 (tick every 4
// cycles). Edge numbering: E0 is the last reset edge; the prescaler is 0 after
// E0, so unpaused ticks fall on E4, E8, ... until the pause shifts the phase.
// Inputs are changed 1 time unit after a rising edge and take effect at the
// next one; outputs are sampled at the same point.
module tb_multi_spawn_timer;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 4;

  logic                    clk;
  logic                    rst_n;
  logic                    pause;
  logic [NUM_CH-1:0]       eaten;
  logic [NUM_CH-1:0]       clear;
  logic [NUM_CH-1:0]       auto_reload;
  logic [NUM_CH*CNT_W-1:0] delay;
  logic [NUM_CH-1:0]       spawn;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH*CNT_W-1:0] remaining;

  int errors = 0;
  int checks = 0;

  multi_spawn_timer #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .PRESCALER(3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pause      (pause),
    .eaten      (eaten),
    .clear      (clear),
    .auto_reload(auto_reload),
    .delay      (delay),
    .spawn      (spawn),
    .busy       (busy),
    .remaining  (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] rem(input int ch);
    return remaining[ch*CNT_W +: CNT_W];
  endfunction

  initial begin
    rst_n       = 1'b0;
    pause       = 1'b0;
    eaten       = '0;
    clear       = '0;
    auto_reload = '0;
    delay       = '0;
    step(2);                                   // E0
    chk("reset_spawn", spawn, 0);
    chk("reset_busy", busy, 0);
    chk("reset_remaining", remaining, 0);

    // Basic: channel 0, delay 3
    rst_n = 1'b1;
    eaten = 4'b0001;
    delay = 16'h0003;
    step(1);                                   // E1 load
    chk("basic_busy_load", busy[0], 1);
    chk("basic_rem_load", rem(0), 3);
    eaten = '0;
    step(2);                                   // E3
    chk("basic_rem_pre_tick", rem(0), 3);
    step(1);                                   // E4 tick
    chk("basic_rem_t1", rem(0), 2);
    step(4);                                   // E8 tick
    chk("basic_rem_t2", rem(0), 1);
    step(3);                                   // E11
    chk("basic_spawn_early", spawn, 0);
    step(1);                                   // E12 expiry
    chk("basic_spawn", spawn, 4'b0001);
    chk("basic_busy_done", busy[0], 0);
    chk("basic_rem_done", rem(0), 0);
    step(1);                                   // E13
    chk("basic_spawn_one_cycle", spawn, 0);

    // Pause: load at E14, ticks E16; pause seen at E17..E26; ticks resume E30
    eaten = 4'b0001;
    step(1);                                   // E14 load
    chk("pause_rem_load", rem(0), 3);
    eaten = '0;
    step(2);                                   // E16 tick
    chk("pause_rem_t1", rem(0), 2);
    pause = 1'b1;
    step(4);                                   // E20: would have ticked
    chk("pause_rem_frozen_a", rem(0), 2);
    step(6);                                   // E26
    chk("pause_rem_frozen_b", rem(0), 2);
    pause = 1'b0;
    step(4);                                   // E30 tick
    chk("pause_rem_t2", rem(0), 1);
    step(3);                                   // E33
    chk("pause_spawn_early", spawn, 0);
    step(1);                                   // E34 expiry (basic + 10)
    chk("pause_spawn", spawn, 4'b0001);
    step(1);                                   // E35
    chk("pause_spawn_one_cycle", spawn, 0);
    chk("pause_busy_done", busy[0], 0);

    // Retrigger on channel 1: ticks now at E38, E42, E46, E50 ...
    eaten = 4'b0010;
    delay = 16'h0020;
    step(1);                                   // E36 load
    chk("retrig_rem_load", rem(1), 2);
    eaten = '0;
    step(2);                                   // E38 tick
    chk("retrig_rem_t1", rem(1), 1);
    step(3);                                   // E41
    eaten = 4'b0010;
    step(1);                                   // E42 expiry tick + eaten
    chk("retrig_no_spawn", spawn, 0);
    chk("retrig_rem_reload", rem(1), 2);
    chk("retrig_busy", busy[1], 1);
    eaten = '0;
    step(4);                                   // E46 tick
    chk("retrig_rem_t2", rem(1), 1);
    step(3);                                   // E49
    chk("retrig_spawn_early", spawn, 0);
    step(1);                                   // E50 expiry
    chk("retrig_spawn", spawn, 4'b0010);
    step(1);                                   // E51
    chk("retrig_busy_done", busy[1], 0);

    // Clear on channel 2 at its expiry tick (E54)
    eaten = 4'b0100;
    delay = 16'h0100;
    step(1);                                   // E52 load
    chk("clear_busy_load", busy[2], 1);
    eaten = '0;
    step(1);                                   // E53
    clear = 4'b0100;
    step(1);                                   // E54 tick + clear
    chk("clear_no_spawn", spawn, 0);
    chk("clear_busy", busy[2], 0);
    chk("clear_rem", rem(2), 0);
    clear = '0;
    step(1);                                   // E55
    chk("clear_no_spawn_late", spawn, 0);

    // Auto-reload on channel 3, delay 1
    eaten       = 4'b1000;
    delay       = 16'h1000;
    auto_reload = 4'b1000;
    step(1);                                   // E56 load
    chk("auto_busy_load", busy[3], 1);
    eaten = '0;
    step(2);                                   // E58 tick
    chk("auto_spawn_1", spawn, 4'b1000);
    chk("auto_busy_1", busy[3], 1);
    chk("auto_rem_1", rem(3), 1);
    step(1);                                   // E59
    chk("auto_spawn_gap", spawn, 0);
    step(3);                                   // E62 tick
    chk("auto_spawn_2", spawn, 4'b1000);
    auto_reload = '0;
    step(4);                                   // E66 tick
    chk("auto_spawn_last", spawn, 4'b1000);
    chk("auto_busy_off", busy[3], 0);
    step(4);                                   // E70 tick
    chk("auto_no_more_spawn", spawn, 0);

    // delay 0 on channel 0
    eaten = 4'b0001;
    delay = 16'h0000;
    step(1);                                   // E71
    chk("zero_spawn", spawn, 4'b0001);
    chk("zero_busy", busy, 0);
    eaten = '0;
    step(1);                                   // E72
    chk("zero_spawn_one_cycle", spawn, 0);

    // delay 15 on channel 1: ticks E74..E130, expiry on the 15th
    eaten = 4'b0010;
    delay = 16'h00F0;
    step(1);                                   // E73 load
    chk("max_rem_load", rem(1), 15);
    eaten = '0;
    step(1);                                   // E74 tick
    chk("max_rem_t1", rem(1), 14);
    step(55);                                  // E129
    chk("max_rem_t14", rem(1), 1);
    chk("max_spawn_early", spawn, 0);
    step(1);                                   // E130 expiry
    chk("max_spawn", spawn, 4'b0010);

    // All four channels, delay 2, loaded together
    eaten = 4'b1111;
    delay = 16'h2222;
    step(1);                                   // E131 load
    chk("all_busy", busy, 4'b1111);
    chk("all_rem", remaining, 16'h2222);
    eaten = '0;
    step(7);                                   // E138 expiry
    chk("all_spawn", spawn, 4'b1111);
    step(1);                                   // E139
    chk("all_spawn_one_cycle", spawn, 0);
    chk("all_busy_done", busy, 0);

    // Reset mid-run
    eaten = 4'b1111;
    delay = 16'h3333;
    step(1);                                   // E140 load
    chk("rst_busy_pre", busy, 4'b1111);
    eaten = '0;
    step(3);                                   // E143
    rst_n = 1'b0;
    step(1);                                   // E144 reset
    chk("rst_spawn", spawn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_remaining", remaining, 0);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step(1);
      chk("rst_no_spawn", spawn, 0);
      chk("rst_stay_idle", busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
